// File: rtl/regfile_dump_pkg.sv
// Shared types and constants for the Mini-SRC register file dump reader.
package regfile_dump_pkg;

  localparam int REG_COUNT   = 16;
  localparam int DUMP_DATA_W = 32;
  localparam int DUMP_SEL_W  = 4;

  // SELECT/SEND alternate per word. CSUM is reachable only when the
  // checksum build option is enabled.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_SEND   = 3'd2,
    S_CSUM   = 3'd3,
    S_DONE   = 3'd4
  } dump_state_t;

  // Next register number. The 4-bit result wraps R15 -> R0, which is what
  // lets a range with first > last walk through the top of the file.
  function automatic logic [DUMP_SEL_W-1:0] wrap_inc(input logic [DUMP_SEL_W-1:0] v);
    return v + DUMP_SEL_W'(1);
  endfunction

endpackage

// File: rtl/dump_xor_accum.sv
// Running 32-bit XOR of streamed register words. A clear wins over an
// accumulate in the same cycle so a new dump always starts from zero.
module dump_xor_accum #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         acc_en_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] acc_o
);

  logic [W-1:0] acc_q;
  logic [W-1:0] acc_d;

  // Next accumulator value: clear, fold in a word, or hold.
  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (acc_en_i) begin
      acc_d = acc_q ^ data_i;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/regfile_dump_reader.sv
// Sequential read-out engine for the 16x32 Mini-SRC register file.
// On in_start it walks the inclusive range first..last (4-bit wrap) through
// the file's A-select port and streams one word per register.
//
// Handshake: out_data/out_index/out_last are meaningful while out_valid=1 and
// stay stable until a rising edge sees out_valid & in_ready; that edge
// transfers the word. out_valid never drops without a transfer.
//
// Build option: define REGDUMP_CHECKSUM_EN to append an XOR checksum word
// (out_index=0, out_last=1) after the last register word.
module regfile_dump_reader
  import regfile_dump_pkg::*;
#(
  parameter int DATA_W = DUMP_DATA_W,
  parameter int SEL_W  = DUMP_SEL_W
) (
  input  logic              in_clk,
  input  logic              in_clr,
  input  logic              in_start,
  input  logic [SEL_W-1:0]  in_first_reg,
  input  logic [SEL_W-1:0]  in_last_reg,
  output logic [SEL_W-1:0]  out_Aselect,
  output logic              out_BAout,
  input  logic [DATA_W-1:0] in_Adata,
  output logic [DATA_W-1:0] out_data,
  output logic [SEL_W-1:0]  out_index,
  output logic              out_valid,
  input  logic              in_ready,
  output logic              out_last,
  output logic              out_busy,
  output logic              out_done,
  output logic [2:0]        out_dbg_state
);

  dump_state_t       state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [SEL_W-1:0]  idx_q, idx_d;
  logic [SEL_W-1:0]  last_reg_q, last_reg_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              lastf_q, lastf_d;
  logic              done_q, done_d;

`ifdef REGDUMP_CHECKSUM_EN
  logic              csum_clr;
  logic              csum_en;
  logic [DATA_W-1:0] csum_val;

  dump_xor_accum #(
    .W (DATA_W)
  ) u_csum (
    .clk_i    (in_clk),
    .rst_ni   (in_clr),
    .clr_i    (csum_clr),
    .acc_en_i (csum_en),
    .data_i   (in_Adata),
    .acc_o    (csum_val)
  );
`endif

  // Next-state and datapath control for the dump walk.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    idx_d      = idx_q;
    last_reg_d = last_reg_q;
    data_d     = data_q;
    valid_d    = valid_q;
    lastf_d    = lastf_q;
    done_d     = 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
    csum_clr   = 1'b0;
    csum_en    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_start) begin
          last_reg_d = in_last_reg;
          sel_d      = in_first_reg;
          idx_d      = in_first_reg;
          state_d    = S_SELECT;
`ifdef REGDUMP_CHECKSUM_EN
          csum_clr   = 1'b1;
`endif
        end
      end

      // A-select has settled for a full cycle; capture the live value.
      S_SELECT: begin
        data_d  = in_Adata;
        valid_d = 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
        lastf_d = 1'b0;
        csum_en = 1'b1;
`else
        lastf_d = (idx_q == last_reg_q);
`endif
        state_d = S_SEND;
      end

      S_SEND: begin
        if (valid_q && in_ready) begin
          valid_d = 1'b0;
          lastf_d = 1'b0;
          if (idx_q == last_reg_q) begin
`ifdef REGDUMP_CHECKSUM_EN
            state_d = S_CSUM;
`else
            done_d  = 1'b1;
            state_d = S_DONE;
`endif
          end else begin
            idx_d   = SEL_W'(wrap_inc(idx_q));
            sel_d   = SEL_W'(wrap_inc(idx_q));
            state_d = S_SELECT;
          end
        end
      end

`ifdef REGDUMP_CHECKSUM_EN
      // First cycle loads the finished checksum (the last register word was
      // folded in at its capture edge); then it is held like any other word.
      S_CSUM: begin
        if (!valid_q) begin
          data_d  = csum_val;
          idx_d   = '0;
          lastf_d = 1'b1;
          valid_d = 1'b1;
        end else if (in_ready) begin
          valid_d = 1'b0;
          lastf_d = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
`endif

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any dump in progress.
  always_ff @(posedge in_clk or negedge in_clr) begin
    if (!in_clr) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      idx_q      <= '0;
      last_reg_q <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      lastf_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      idx_q      <= idx_d;
      last_reg_q <= last_reg_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      lastf_q    <= lastf_d;
      done_q     <= done_d;
    end
  end

  assign out_Aselect   = sel_q;
  assign out_BAout     = 1'b0;
  assign out_data      = data_q;
  assign out_index     = idx_q;
  assign out_valid     = valid_q;
  assign out_last      = lastf_q;
  assign out_busy      = (state_q != S_IDLE);
  assign out_done      = done_q;
  assign out_dbg_state = state_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader with a behavioural 16x32 file.
module tb_regfile_dump_reader;

`ifdef REGDUMP_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic        in_clk = 1'b0;
  logic        in_clr;
  logic        in_start;
  logic [3:0]  in_first_reg;
  logic [3:0]  in_last_reg;
  logic [3:0]  out_Aselect;
  logic        out_BAout;
  logic [31:0] in_Adata;
  logic [31:0] out_data;
  logic [3:0]  out_index;
  logic        out_valid;
  logic        in_ready;
  logic        out_last;
  logic        out_busy;
  logic        out_done;
  logic [2:0]  out_dbg_state;

  logic [31:0] rf [16];

  int checks = 0;
  int errors = 0;

  // Observation buffers filled by run_dump
  logic [31:0] obs_data [$];
  logic [3:0]  obs_idx [$];
  logic        obs_last [$];
  logic [31:0] stall_data [$];
  logic [3:0]  stall_idx [$];
  int done_cyc;
  int done_cnt;
  int busy_low;
  int stall_word = -1;
  int stall_len = 0;
  int poke_cyc = 0;

  regfile_dump_reader dut (
    .in_clk        (in_clk),
    .in_clr        (in_clr),
    .in_start      (in_start),
    .in_first_reg  (in_first_reg),
    .in_last_reg   (in_last_reg),
    .out_Aselect   (out_Aselect),
    .out_BAout     (out_BAout),
    .in_Adata      (in_Adata),
    .out_data      (out_data),
    .out_index     (out_index),
    .out_valid     (out_valid),
    .in_ready      (in_ready),
    .out_last      (out_last),
    .out_busy      (out_busy),
    .out_done      (out_done),
    .out_dbg_state (out_dbg_state)
  );

  // Combinational register-file read; BA-out is assumed 0 here and checked
  assign in_Adata = rf[out_Aselect];

  // Clock
  always #5 in_clk = ~in_clk;

  // Driver: raise in_start for the next rising edge (edge k)
  task automatic do_start(input logic [3:0] f, input logic [3:0] l);
    @(negedge in_clk);
    in_first_reg = f;
    in_last_reg  = l;
    in_start     = 1'b1;
  endtask

  // Driver/monitor: runs a dump started by do_start; cycle 1 is the negedge
  // after edge k. Records every transferred word and every stalled sample.
  task automatic run_dump(input int max_cyc);
    int cyc;
    int n;
    int left;
    int after;
    obs_data.delete();
    obs_idx.delete();
    obs_last.delete();
    stall_data.delete();
    stall_idx.delete();
    done_cyc = -1;
    done_cnt = 0;
    busy_low = 0;
    cyc = 0;
    n = 0;
    left = stall_len;
    after = -1;
    while (cyc < max_cyc && (after < 0 || cyc < after + 3)) begin
      @(negedge in_clk);
      cyc++;
      in_start = (cyc == poke_cyc);
      if (cyc == poke_cyc) begin
        in_first_reg = 4'd9;
        in_last_reg  = 4'd9;
      end
      if (out_done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          after = cyc;
        end
      end
      if (after < 0 && !out_busy) busy_low++;
      in_ready = 1'b1;
      if (out_valid && n == stall_word && left > 0) begin
        in_ready = 1'b0;
        left--;
        stall_data.push_back(out_data);
        stall_idx.push_back(out_index);
      end
      if (out_valid && in_ready) begin
        obs_data.push_back(out_data);
        obs_idx.push_back(out_index);
        obs_last.push_back(out_last);
        n++;
      end
    end
    in_start = 1'b0;
    in_ready = 1'b1;
  endtask

  task automatic test_reset;
    in_clr = 1'b0;
    in_start = 1'b0;
    in_ready = 1'b1;
    in_first_reg = 4'd0;
    in_last_reg = 4'd0;
    #2;
    checks++;
    if ({out_Aselect, out_BAout, out_data, out_index, out_valid, out_last, out_busy, out_done} !== 45'd0) begin
      errors++;
      $display("FAIL reset_outputs: got sel=%h ba=%b data=%h idx=%h v=%b l=%b busy=%b done=%b expected all zero",
               out_Aselect, out_BAout, out_data, out_index, out_valid, out_last, out_busy, out_done);
    end
    checks++;
    if (out_dbg_state !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d expected 0", out_dbg_state);
    end
    repeat (2) @(negedge in_clk);
    in_clr = 1'b1;
    repeat (2) @(negedge in_clk);
  endtask

  task automatic test_full;
    for (int i = 0; i < 16; i++) rf[i] = 32'(i) * 32'h1111_1111;
    do_start(4'd0, 4'd15);
    run_dump(200);
    checks++;
    if (obs_data.size() !== 16 + CS) begin
      errors++;
      $display("FAIL full_count: got %0d expected %0d", obs_data.size(), 16 + CS);
    end
    for (int i = 0; i < 16; i++) begin
      if (i < obs_data.size()) begin
        checks++;
        if (obs_data[i] !== 32'(i) * 32'h1111_1111 || obs_idx[i] !== 4'(i) || obs_last[i] !== (i == 15 - CS + CS * 16)) begin
          errors++;
          $display("FAIL full_word%0d: got data=%h idx=%0d last=%b expected data=%h idx=%0d last=%b",
                   i, obs_data[i], obs_idx[i], obs_last[i], 32'(i) * 32'h1111_1111, i, (i == 15 - CS + CS * 16));
        end
      end
    end
    checks++;
    if (done_cyc !== 33 + 2 * CS || done_cnt !== 1) begin
      errors++;
      $display("FAIL full_done: got cycle=%0d pulses=%0d expected cycle=%0d pulses=1", done_cyc, done_cnt, 33 + 2 * CS);
    end
    checks++;
    if (busy_low !== 0 || out_busy !== 1'b0) begin
      errors++;
      $display("FAIL full_busy: got early_low=%0d final=%b expected 0 and 0", busy_low, out_busy);
    end
    checks++;
    if (out_BAout !== 1'b0) begin
      errors++;
      $display("FAIL full_baout: got %b expected 0", out_BAout);
    end
  endtask

  task automatic test_wrap;
    int exp_i [4] = '{14, 15, 0, 1};
    for (int i = 0; i < 16; i++) rf[i] = 32'hA500_0000 | 32'(i);
    do_start(4'd14, 4'd1);
    run_dump(100);
    checks++;
    if (obs_data.size() !== 4 + CS) begin
      errors++;
      $display("FAIL wrap_count: got %0d expected %0d", obs_data.size(), 4 + CS);
    end
    for (int i = 0; i < 4; i++) begin
      if (i < obs_data.size()) begin
        checks++;
        if (obs_idx[i] !== 4'(exp_i[i]) || obs_data[i] !== (32'hA500_0000 | 32'(exp_i[i])) || obs_last[i] !== (i == 3 + CS * 8)) begin
          errors++;
          $display("FAIL wrap_word%0d: got idx=%0d data=%h last=%b expected idx=%0d data=%h last=%b",
                   i, obs_idx[i], obs_data[i], obs_last[i], exp_i[i], 32'hA500_0000 | 32'(exp_i[i]), (i == 3 + CS * 8));
        end
      end
    end
    checks++;
    if (done_cyc !== 9 + 2 * CS) begin
      errors++;
      $display("FAIL wrap_done: got %0d expected %0d", done_cyc, 9 + 2 * CS);
    end
  endtask

  task automatic test_all16_wrap;
    do_start(4'd3, 4'd2);
    run_dump(200);
    checks++;
    if (obs_data.size() !== 16 + CS) begin
      errors++;
      $display("FAIL all16_count: got %0d expected %0d", obs_data.size(), 16 + CS);
    end
    for (int i = 0; i < 16; i++) begin
      if (i < obs_idx.size()) begin
        checks++;
        if (obs_idx[i] !== 4'((i + 3) % 16)) begin
          errors++;
          $display("FAIL all16_idx%0d: got %0d expected %0d", i, obs_idx[i], (i + 3) % 16);
        end
      end
    end
  endtask

  task automatic test_single;
    rf[5] = 32'hDEAD_BEEF;
    do_start(4'd5, 4'd5);
    run_dump(50);
    checks++;
    if (obs_data.size() !== 1 + CS) begin
      errors++;
      $display("FAIL single_count: got %0d expected %0d", obs_data.size(), 1 + CS);
    end
    checks++;
    if (obs_data[0] !== 32'hDEAD_BEEF || obs_idx[0] !== 4'd5 || obs_last[0] !== (CS == 0)) begin
      errors++;
      $display("FAIL single_word: got data=%h idx=%0d last=%b expected data=deadbeef idx=5 last=%b",
               obs_data[0], obs_idx[0], obs_last[0], (CS == 0));
    end
    checks++;
    if (done_cyc !== 3 + 2 * CS) begin
      errors++;
      $display("FAIL single_done: got %0d expected %0d", done_cyc, 3 + 2 * CS);
    end
  endtask

  task automatic test_back_pressure;
    for (int i = 0; i < 16; i++) rf[i] = 32'h0101_0101 * 32'(i + 1);
    stall_word = 2;
    stall_len = 3;
    poke_cyc = 4;
    do_start(4'd0, 4'd4);
    run_dump(100);
    stall_word = -1;
    stall_len = 0;
    poke_cyc = 0;
    checks++;
    if (obs_data.size() !== 5 + CS) begin
      errors++;
      $display("FAIL bp_count: got %0d expected %0d", obs_data.size(), 5 + CS);
    end
    for (int i = 0; i < 5; i++) begin
      if (i < obs_data.size()) begin
        checks++;
        if (obs_idx[i] !== 4'(i) || obs_data[i] !== 32'h0101_0101 * 32'(i + 1)) begin
          errors++;
          $display("FAIL bp_word%0d: got idx=%0d data=%h expected idx=%0d data=%h",
                   i, obs_idx[i], obs_data[i], i, 32'h0101_0101 * 32'(i + 1));
        end
      end
    end
    checks++;
    if (stall_data.size() !== 3) begin
      errors++;
      $display("FAIL bp_stall_count: got %0d expected 3", stall_data.size());
    end
    for (int i = 0; i < stall_data.size(); i++) begin
      checks++;
      if (stall_data[i] !== 32'h0303_0303 || stall_idx[i] !== 4'd2) begin
        errors++;
        $display("FAIL bp_stable%0d: got data=%h idx=%0d expected data=03030303 idx=2",
                 i, stall_data[i], stall_idx[i]);
      end
    end
    checks++;
    if (done_cyc !== 14 + 2 * CS || done_cnt !== 1) begin
      errors++;
      $display("FAIL bp_done: got cycle=%0d pulses=%0d expected cycle=%0d pulses=1", done_cyc, done_cnt, 14 + 2 * CS);
    end
    checks++;
    if (out_busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_start_ignored: got busy=%b valid=%b expected 0 0", out_busy, out_valid);
    end
  endtask

  task automatic test_reset_mid;
    int seen_done;
    int seen_valid;
    for (int i = 0; i < 16; i++) rf[i] = 32'hFFFF_0000 | 32'(i);
    do_start(4'd0, 4'd15);
    @(negedge in_clk);
    in_start = 1'b0;
    repeat (5) @(negedge in_clk);
    checks++;
    if (out_valid !== 1'b1 || out_dbg_state !== 3'd2) begin
      errors++;
      $display("FAIL midrst_pre: got valid=%b state=%0d expected valid=1 state=2", out_valid, out_dbg_state);
    end
    #2;
    in_clr = 1'b0;
    #1;
    checks++;
    if ({out_Aselect, out_BAout, out_data, out_index, out_valid, out_last, out_busy, out_done} !== 45'd0) begin
      errors++;
      $display("FAIL midrst_outputs: got sel=%h data=%h idx=%h v=%b l=%b busy=%b done=%b expected all zero",
               out_Aselect, out_data, out_index, out_valid, out_last, out_busy, out_done);
    end
    checks++;
    if (out_dbg_state !== 3'd0) begin
      errors++;
      $display("FAIL midrst_state: got %0d expected 0", out_dbg_state);
    end
    @(negedge in_clk);
    in_clr = 1'b1;
    seen_done = 0;
    seen_valid = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge in_clk);
      if (out_done) seen_done++;
      if (out_valid || out_busy) seen_valid++;
    end
    checks++;
    if (seen_done !== 0 || seen_valid !== 0 || out_dbg_state !== 3'd0) begin
      errors++;
      $display("FAIL midrst_after: got done_pulses=%0d active_cycles=%0d state=%0d expected 0 0 0",
               seen_done, seen_valid, out_dbg_state);
    end
  endtask

`ifdef REGDUMP_CHECKSUM_EN
  task automatic test_checksum;
    rf[0] = 32'h1111_1111;
    rf[1] = 32'h1111_0000;
    do_start(4'd0, 4'd1);
    run_dump(50);
    checks++;
    if (obs_data.size() !== 3) begin
      errors++;
      $display("FAIL csum_count: got %0d expected 3", obs_data.size());
    end
    checks++;
    if (obs_data[2] !== 32'h0000_1111 || obs_idx[2] !== 4'd0 || obs_last[2] !== 1'b1) begin
      errors++;
      $display("FAIL csum_word: got data=%h idx=%0d last=%b expected data=00001111 idx=0 last=1",
               obs_data[2], obs_idx[2], obs_last[2]);
    end
    checks++;
    if (obs_last[0] !== 1'b0 || obs_last[1] !== 1'b0) begin
      errors++;
      $display("FAIL csum_reg_last: got %b %b expected 0 0", obs_last[0], obs_last[1]);
    end
    checks++;
    if (done_cyc !== 7) begin
      errors++;
      $display("FAIL csum_done: got %0d expected 7", done_cyc);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_full();
    test_wrap();
    test_all16_wrap();
    test_single();
    test_back_pressure();
`ifdef REGDUMP_CHECKSUM_EN
    test_checksum();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
